// File: rtl/jts16_scr_pkg.sv
// Shared types and constants for the scroll-layer fetch scheduler.
package jts16_scr_pkg;

    localparam int unsigned PAGE_W      = 3;
    localparam int unsigned COL_W       = 8;
    localparam logic [8:0]  HOFS_DEF    = 9'd8;
    localparam int unsigned CODE_HI_BIT = 13;
    localparam int unsigned CODE_LO_W   = 12;
    localparam int unsigned ATTR_HI_BIT = 15;
    localparam int unsigned ATTR_LO_BIT = 14;
    localparam int unsigned ATTR_MID    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FG_MAP,
        ST_FG_ROM,
        ST_BG_MAP,
        ST_BG_ROM,
        ST_DONE
    } state_t;

    function automatic logic [12:0] map_code(input logic [15:0] w);
        return {w[CODE_HI_BIT], w[CODE_LO_W-1:0]};
    endfunction

    function automatic logic [2:0] map_attr(input logic [15:0] w);
        return {w[ATTR_HI_BIT], w[ATTR_LO_BIT], w[ATTR_MID]};
    endfunction

    // Page nibble is picked by the top bits of both scroll positions
    function automatic logic [13:0] map_addr_of(input logic [15:0] pages,
                                                input logic [9:0]  hpos,
                                                input logic [8:0]  vpos);
        logic [1:0]        idx;
        logic [PAGE_W-1:0] page;
        idx  = {vpos[8], hpos[9]};
        page = pages[{idx, 2'b00} +: PAGE_W];
        return {page, vpos[7:3], hpos[8:3]};
    endfunction

endpackage

// File: rtl/jts16_scr_fetch_req.sv
// One request/ok handshake slot: holds cs, ignores ok on the first cs clock.
module jts16_scr_req (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic drop,
    input  logic ok,
    output logic cs,
    output logic capture_c
);

    logic armed;

    assign capture_c = cs && armed && ok && !drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs    <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= cs && !drop;
            if (drop || capture_c) begin
                cs <= 1'b0;
            end else if (start) begin
                cs <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jts16_scr_fetch.sv
// FG/BG scroll map+tile fetch scheduler, one column ahead of the beam.
// Optional JTS16_SCR_FETCH_STATS_EN adds miss_cnt and lat_max outputs.
module jts16_scr_fetch
    import jts16_scr_pkg::*;
#(
    parameter logic [8:0] HOFS = HOFS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic [8:0]  hdump,
    input  logic [8:0]  vdump,
    input  logic [31:0] pages,
    input  logic [19:0] hscr,
    input  logic [17:0] vscr,
    output logic        map_cs,
    output logic [13:0] map_addr,
    input  logic        map_ok,
    input  logic [15:0] map_data,
    output logic        scr_cs,
    output logic [15:0] scr_addr,
    input  logic        scr_ok,
    input  logic [31:0] scr_data,
    output logic        col_vld,
    output logic [15:0] fg_map,
    output logic [31:0] fg_tile,
    output logic [15:0] bg_map,
    output logic [31:0] bg_tile,
    output logic        miss
`ifdef JTS16_SCR_FETCH_STATS_EN
    ,
    output logic [15:0] miss_cnt,
    output logic [5:0]  lat_max
`endif
);

    localparam int unsigned COL_LSB = $clog2(COL_W);

    state_t      state, state_nx;
    logic        col_start_c, late_c, restart;
    logic        map_start_c, rom_start_c, map_cap_c, rom_cap_c;
    logic [9:0]  fg_hpos_c, bg_hpos_c;
    logic [8:0]  fg_vpos_c, bg_vpos_c;
    logic [13:0] bg_addr;
    logic [2:0]  fg_vrow, bg_vrow;
    logic [15:0] fg_map_sh, bg_map_sh;
    logic [31:0] fg_tile_sh, bg_tile_sh;

    assign col_start_c = pxl_cen && (hdump[COL_LSB-1:0] == '0);
    assign late_c      = col_start_c && (state != ST_IDLE) && (state != ST_DONE);
    assign fg_hpos_c   = 10'(hdump) + 10'(HOFS) + hscr[9:0];
    assign bg_hpos_c   = 10'(hdump) + 10'(HOFS) + hscr[19:10];
    assign fg_vpos_c   = vdump + vscr[8:0];
    assign bg_vpos_c   = vdump + vscr[17:9];

    jts16_scr_req u_map (
        .clk       (clk),
        .rst       (rst),
        .start     (map_start_c),
        .drop      (late_c),
        .ok        (map_ok),
        .cs        (map_cs),
        .capture_c (map_cap_c)
    );

    jts16_scr_req u_rom (
        .clk       (clk),
        .rst       (rst),
        .start     (rom_start_c),
        .drop      (late_c),
        .ok        (scr_ok),
        .cs        (scr_cs),
        .capture_c (rom_cap_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            restart <= 1'b0;
        end else begin
            state   <= state_nx;
            restart <= late_c;
        end
    end

    // A late column drops cs for one clock before the map request is reissued
    always_comb begin
        state_nx    = state;
        map_start_c = 1'b0;
        rom_start_c = 1'b0;
        if (col_start_c) begin
            state_nx    = ST_FG_MAP;
            map_start_c = !late_c;
        end else if (restart) begin
            map_start_c = 1'b1;
        end else begin
            case (state)
                ST_FG_MAP: if (map_cap_c) begin
                    state_nx    = ST_FG_ROM;
                    rom_start_c = 1'b1;
                end
                ST_FG_ROM: if (rom_cap_c) begin
                    state_nx    = ST_BG_MAP;
                    map_start_c = 1'b1;
                end
                ST_BG_MAP: if (map_cap_c) begin
                    state_nx    = ST_BG_ROM;
                    rom_start_c = 1'b1;
                end
                ST_BG_ROM: if (rom_cap_c) begin
                    state_nx = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_addr <= '0;
            scr_addr <= '0;
            bg_addr  <= '0;
            fg_vrow  <= '0;
            bg_vrow  <= '0;
        end else begin
            if (col_start_c) begin
                map_addr <= map_addr_of(pages[15:0], fg_hpos_c, fg_vpos_c);
                bg_addr  <= map_addr_of(pages[31:16], bg_hpos_c, bg_vpos_c);
                fg_vrow  <= fg_vpos_c[2:0];
                bg_vrow  <= bg_vpos_c[2:0];
            end else if (rom_cap_c && state == ST_FG_ROM) begin
                map_addr <= bg_addr;
            end
            if (map_cap_c) begin
                scr_addr <= {map_code(map_data), (state == ST_FG_MAP) ? fg_vrow : bg_vrow};
            end
        end
    end

    // Shadow capture and column handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            fg_map_sh  <= '0;
            bg_map_sh  <= '0;
            fg_tile_sh <= '0;
            bg_tile_sh <= '0;
            fg_map     <= '0;
            bg_map     <= '0;
            fg_tile    <= '0;
            bg_tile    <= '0;
            col_vld    <= 1'b0;
            miss       <= 1'b0;
        end else begin
            if (map_cap_c) begin
                if (state == ST_FG_MAP) fg_map_sh <= map_data;
                else                    bg_map_sh <= map_data;
            end
            if (rom_cap_c) begin
                if (state == ST_FG_ROM) fg_tile_sh <= scr_data;
                else                    bg_tile_sh <= scr_data;
            end
            col_vld <= 1'b0;
            if (col_start_c && state == ST_DONE) begin
                fg_map  <= fg_map_sh;
                bg_map  <= bg_map_sh;
                fg_tile <= fg_tile_sh;
                bg_tile <= bg_tile_sh;
                col_vld <= 1'b1;
                miss    <= 1'b0;
            end else if (late_c) begin
                miss <= 1'b1;
            end
        end
    end

`ifdef JTS16_SCR_FETCH_STATS_EN
    logic [5:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt <= '0;
            lat_max  <= '0;
            lat_cnt  <= '0;
        end else begin
            if (late_c && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (col_start_c) begin
                lat_cnt <= 6'd1;
            end else if (lat_cnt != 6'd63 && state != ST_DONE && state != ST_IDLE) begin
                lat_cnt <= lat_cnt + 6'd1;
            end
            if (state_nx == ST_DONE && state != ST_DONE && lat_cnt > lat_max) begin
                lat_max <= lat_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jts16_scr_fetch.sv
// Self-checking bench for jts16_scr_fetch: memory responder, column model, directed tests.
module tb_jts16_scr_fetch;

    localparam int HOFS_I = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_cen = 1'b0;
    logic [8:0]  hdump = '0;
    logic [8:0]  vdump = '0;
    logic [31:0] pages = '0;
    logic [19:0] hscr = '0;
    logic [17:0] vscr = '0;
    logic        map_cs;
    logic [13:0] map_addr;
    logic        map_ok = 1'b0;
    logic [15:0] map_data = '0;
    logic        scr_cs;
    logic [15:0] scr_addr;
    logic        scr_ok = 1'b0;
    logic [31:0] scr_data = '0;
    logic        col_vld;
    logic [15:0] fg_map, bg_map;
    logic [31:0] fg_tile, bg_tile;
    logic        miss;

    jts16_scr_fetch dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hdump(hdump), .vdump(vdump),
        .pages(pages), .hscr(hscr), .vscr(vscr),
        .map_cs(map_cs), .map_addr(map_addr), .map_ok(map_ok), .map_data(map_data),
        .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(scr_ok), .scr_data(scr_data),
        .col_vld(col_vld), .fg_map(fg_map), .fg_tile(fg_tile), .bg_map(bg_map),
        .bg_tile(bg_tile), .miss(miss)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int div = 0;
    bit chk_en = 1'b0;
    bit map_fixed = 1'b0;
    bit ok_early = 1'b0;
    bit stall_req = 1'b0;
    int pulse_len_exp = 0;

    // model state
    bit          e_vld = 1'b0, e_miss = 1'b0, pend = 1'b0, p_good = 1'b0;
    logic [15:0] e_fg_map = '0, e_bg_map = '0, p_fg_map = '0, p_bg_map = '0;
    logic [31:0] e_fg_tile = '0, e_bg_tile = '0, p_fg_tile = '0, p_bg_tile = '0;
    int          col_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] map_mem(input logic [13:0] a, input bit fixed);
        return fixed ? 16'h2ABC : (16'(a) ^ 16'hA5C3);
    endfunction

    function automatic logic [31:0] rom_mem(input logic [15:0] a);
        return {a ^ 16'h3C3C, ~a};
    endfunction

    // What one layer must deliver for a column started with these inputs
    task automatic layer_expect(input logic [8:0] hd, input logic [8:0] vd, input logic [15:0] pg,
                                input logic [9:0] hs, input logic [8:0] vs, input bit fixed,
                                output logic [15:0] m, output logic [31:0] t);
        int h, v, idx, page, maddr, code, raddr;
        h     = (int'(hd) + HOFS_I + int'(hs)) % 1024;
        v     = (int'(vd) + int'(vs)) % 512;
        idx   = (v / 256) * 2 + (h / 512);
        page  = (int'(pg) >> (idx * 4)) % 8;
        maddr = page * 2048 + ((v / 8) % 32) * 64 + (h / 8) % 64;
        m     = map_mem(14'(maddr), fixed);
        code  = ((int'(m) >> 13) % 2) * 4096 + int'(m) % 4096;
        raddr = code * 8 + v % 8;
        t     = rom_mem(16'(raddr));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            e_vld = 1'b0; e_miss = 1'b0; pend = 1'b0;
            e_fg_map = '0; e_bg_map = '0; e_fg_tile = '0; e_bg_tile = '0;
        end else begin
            e_vld = 1'b0;
            if (pxl_cen && hdump[2:0] == 3'd0) begin
                if (pend) begin
                    if (p_good) begin
                        e_fg_map = p_fg_map; e_bg_map = p_bg_map;
                        e_fg_tile = p_fg_tile; e_bg_tile = p_bg_tile;
                        e_vld = 1'b1; e_miss = 1'b0;
                    end else begin
                        e_miss = 1'b1;
                    end
                end
                layer_expect(hdump, vdump, pages[15:0], hscr[9:0], vscr[8:0], map_fixed, p_fg_map, p_fg_tile);
                layer_expect(hdump, vdump, pages[31:16], hscr[19:10], vscr[17:9], map_fixed, p_bg_map, p_bg_tile);
                pend   = 1'b1;
                p_good = !stall_req;
                col_id++;
            end
        end
    end

    // Memory responder: ok three clocks after cs, optional ROM stall of 70 clocks
    initial begin
        int map_n = 0, scr_n = 0, stall_cnt = 0, stalled_id = -1;
        forever begin
            @(negedge clk);
            map_n = map_cs ? map_n + 1 : 0;
            scr_n = scr_cs ? scr_n + 1 : 0;
            if (stall_cnt > 0) stall_cnt--;
            if (scr_cs && pend && !p_good && stalled_id != col_id) begin
                stall_cnt  = 70;
                stalled_id = col_id;
            end
            map_ok   = ok_early ? 1'b1 : (map_cs && map_n >= 3);
            scr_ok   = ok_early ? 1'b1 : (scr_cs && scr_n >= 3 && stall_cnt == 0);
            map_data = map_mem(map_addr, map_fixed);
            scr_data = rom_mem(scr_addr);
        end
    end

    // Per-cycle compare against the model, plus request pulse lengths
    initial begin
        int map_len = 0, scr_len = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("col_vld", 64'(col_vld), 64'(e_vld));
                check("miss", 64'(miss), 64'(e_miss));
                check("fg_map", 64'(fg_map), 64'(e_fg_map));
                check("fg_tile", 64'(fg_tile), 64'(e_fg_tile));
                check("bg_map", 64'(bg_map), 64'(e_bg_map));
                check("bg_tile", 64'(bg_tile), 64'(e_bg_tile));
            end
            if (map_cs) map_len++;
            else begin
                if (map_len > 0 && pulse_len_exp > 0) check("map_cs_len", 64'(map_len), 64'(pulse_len_exp));
                map_len = 0;
            end
            if (scr_cs) scr_len++;
            else begin
                if (scr_len > 0 && pulse_len_exp > 0) check("scr_cs_len", 64'(scr_len), 64'(pulse_len_exp));
                scr_len = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (pxl_cen) hdump = hdump + 9'd1;
        div     = (div + 1) % 8;
        pxl_cen = (div == 7);
    endtask

    // Leaves the bench at the negedge just before a column start
    task automatic next_col();
        do step(); while (!(pxl_cen && hdump[2:0] == 3'd0));
    endtask

    task automatic wait_scr_rise(input string name);
        logic prev;
        bit   got;
        prev = scr_cs;
        got  = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            step();
            if (scr_cs && !prev) got = 1'b1;
            prev = scr_cs;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scr_cs rise not seen within 64 clk", name);
        end
    endtask

    initial begin
        // reset state
        step();
        chk_en = 1'b1;
        step();
        step();
        check("rst_map_cs", 64'(map_cs), 64'(0));
        check("rst_scr_cs", 64'(scr_cs), 64'(0));
        check("rst_fg_map", 64'(fg_map), 64'(0));
        rst = 1'b0;

        // 1: plain columns, ok after 3 clk
        pulse_len_exp = 3;
        next_col();
        hdump = 9'd16;
        step();
        check("t1_map_cs", 64'(map_cs), 64'(1));
        check("t1_map_addr", 64'(map_addr), 64'(14'h0003));
        next_col();
        step();
        check("t1_map_addr_next", 64'(map_addr), 64'(14'h0004));
        next_col();
        next_col();

        // 2: FG hpos wrap to 0 (page 0) then hpos[9]=1 (page 1)
        hdump = 9'd0; hscr = 20'h003F8; pages = 32'h0000_0053;
        step();
        check("t2_wrap_addr", 64'(map_addr), 64'(14'h1800));
        next_col();
        hdump = 9'd0; hscr = 20'h00200;
        step();
        check("t2_page5_addr", 64'(map_addr), 64'(14'h2801));
        next_col();

        // 3: fixed map word, ROM address FG then BG
        hdump = 9'd0; hscr = '0; pages = '0; vdump = 9'd5; vscr = {9'd2, 9'd0}; map_fixed = 1'b1;
        step();
        wait_scr_rise("t3_fg_rom");
        check("t3_fg_scr_addr", 64'(scr_addr), 64'(16'hD5E5));
        wait_scr_rise("t3_bg_rom");
        check("t3_bg_scr_addr", 64'(scr_addr), 64'(16'hD5E7));
        next_col();
        map_fixed = 1'b0; vdump = 9'd40; vscr = {9'd300, 9'd7}; hscr = {10'd513, 10'd77}; pages = 32'h7654_3210;
        step();
        check("t3_fg_map", 64'(fg_map), 64'(16'h2ABC));
        check("t3_fg_tile", 64'(fg_tile), 64'(32'hE9D92A1A));
        check("t3_bg_tile", 64'(bg_tile), 64'(32'hE9DB2A18));
        next_col();

        // 4: ROM stall past the deadline
        pulse_len_exp = 0;
        stall_req = 1'b1;
        next_col();
        stall_req = 1'b0;
        step();
        check("t4_miss", 64'(miss), 64'(1));
        check("t4_no_vld", 64'(col_vld), 64'(0));
        check("t4_drop_scr", 64'(scr_cs), 64'(0));
        check("t4_drop_map", 64'(map_cs), 64'(0));
        step();
        check("t4_restart_map", 64'(map_cs), 64'(1));
        next_col();
        step();
        check("t4_recover_vld", 64'(col_vld), 64'(1));
        check("t4_recover_miss", 64'(miss), 64'(0));
        next_col();

        // 5: ok already high before cs
        ok_early = 1'b1;
        pulse_len_exp = 2;
        next_col();
        next_col();
        next_col();
        ok_early = 1'b0;
        pulse_len_exp = 0;

        // 6: reset during BG_ROM
        step();
        wait_scr_rise("t6_fg_rom");
        wait_scr_rise("t6_bg_rom");
        rst = 1'b1;
        step();
        check("t6_map_cs", 64'(map_cs), 64'(0));
        check("t6_scr_cs", 64'(scr_cs), 64'(0));
        check("t6_fg_tile", 64'(fg_tile), 64'(0));
        rst = 1'b0;
        next_col();
        step();
        check("t6_first_vld", 64'(col_vld), 64'(0));
        next_col();
        step();
        check("t6_second_vld", 64'(col_vld), 64'(1));
        next_col();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
